// File: rtl/rr_grant_encoder.sv
// Four-requester round-robin arbiter producing {a,b}/enb for a 2-to-4 decoder.
// Define ARB_TIMEOUT_EN to build the MAX_HOLD forced-release hold counter.
module rr_grant_encoder #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic       a,
  output logic       b,
  output logic       enb,
  output logic       timeout
);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t     r_state;
  logic [1:0] r_sel;
  logic [1:0] r_ptr;
  logic       r_enb;
  logic       r_armed;

  logic [7:0] w_req2;
  logic [2:0] w_base;
  logic [3:0] w_rot;
  logic [1:0] w_off;
  logic       w_pick_vld;
  logic [1:0] w_pick;
  logic       w_held;

  if ((MAX_HOLD < 1) || (MAX_HOLD > 255) || ((1 << CNT_W) <= MAX_HOLD)) begin : g_bad_param
    $error("rr_grant_encoder: MAX_HOLD must be 1..255 and fit in CNT_W bits");
  end

  // Rotate the request vector so bit 0 is the requester just after the last grant.
  assign w_req2 = {req, req};
  assign w_base = {1'b0, r_ptr} + 3'd1;
  assign w_rot  = w_req2[w_base +: 4];

  always_comb begin
    w_off      = 2'd0;
    w_pick_vld = 1'b1;
    casez (w_rot)
      4'b???1: w_off = 2'd0;
      4'b??10: w_off = 2'd1;
      4'b?100: w_off = 2'd2;
      4'b1000: w_off = 2'd3;
      default: w_pick_vld = 1'b0;
    endcase
  end

  assign w_pick = r_ptr + 2'd1 + w_off;
  assign w_held = req[r_sel];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  logic             w_expire;

  // r_cnt is 0 during the first granted cycle, so MAX_HOLD-1 marks MAX_HOLD cycles high.
  assign w_expire = (r_cnt >= CNT_W'(MAX_HOLD - 1));
  assign timeout  = r_timeout;
`else
  assign timeout  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sel     <= 2'd0;
      r_ptr     <= 2'd3;
      r_enb     <= 1'b0;
      r_armed   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_cnt     <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      // The first edge after reset release only arms the arbiter.
      r_armed <= 1'b1;
`ifdef ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (r_armed && w_pick_vld) begin
            r_sel   <= w_pick;
            r_enb   <= 1'b1;
            r_state <= S_GRANT;
`ifdef ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_GRANT: begin
          if (!w_held) begin
            r_enb   <= 1'b0;
            r_ptr   <= r_sel;
            r_state <= S_IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (w_expire) begin
            r_enb     <= 1'b0;
            r_ptr     <= r_sel;
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign a   = r_sel[1];
  assign b   = r_sel[0];
  assign enb = r_enb;

endmodule
